jelly_cpu_divider_stream: RTL and testbench

Parametrised iterative integer divider for the MIPS-like CPU core, successor to the fixed 1-bit/cycle divider. It adds a valid/ready handshake on both sides, a configurable number of quotient bits retired per cycle, a user tag carried with each operation, and defined divide-by-zero results with a flag. It sits beside the ALU in the execute stage and feeds the HI/LO (remainder/quotient) write-back path.

---
 rtl/jelly_cpu_divider_stream.sv | 152 +++++++++++++++
 tb/tb_jelly_cpu_divider_stream.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_cpu_divider_stream.sv
// Iterative restoring divider with valid/ready streams, BITS_PER_CYCLE quotient bits per cycle.
// Define JELLY_CPU_DIVIDER_ZERO_FAST_EN to let a zero divisor skip the iteration cycles.
module jelly_cpu_divider_stream #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int USER_WIDTH     = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_signed,
    input  logic [DATA_WIDTH-1:0] s_dividend,
    input  logic [DATA_WIDTH-1:0] s_divisor,
    input  logic [USER_WIDTH-1:0] s_user,

    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_quotient,
    output logic [DATA_WIDTH-1:0] m_remainder,
    output logic                  m_div_by_zero,
    output logic [USER_WIDTH-1:0] m_user
);

    localparam int W  = DATA_WIDTH;
    localparam int N  = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [W-1:0]          rem;
    logic [W-1:0]          quo;
    logic [W-1:0]          div;
    logic [W-1:0]          dvd;
    logic                  q_neg;
    logic                  r_neg;
    logic                  zero;
    logic [USER_WIDTH-1:0] user;

    logic                  a_neg;
    logic                  b_neg;
    logic [W-1:0]          r_nxt;
    logic [W-1:0]          q_nxt;
    logic [W:0]            t;
    logic                  last;
    logic                  finish;
    logic [W-1:0]          res_q;
    logic [W-1:0]          res_r;

    assign a_neg = s_signed & s_dividend[W-1];
    assign b_neg = s_signed & s_divisor[W-1];
    assign last  = (cnt == CW'(N - 1));

`ifdef JELLY_CPU_DIVIDER_ZERO_FAST_EN
    assign finish = last | zero;
`else
    assign finish = last;
`endif

    // quo shifts dividend bits out at the top and quotient bits in at the bottom
    always_comb begin
        r_nxt = rem;
        q_nxt = quo;
        t     = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            t     = {r_nxt, q_nxt[W-1]};
            q_nxt = {q_nxt[W-2:0], 1'b0};
            if (t >= {1'b0, div}) begin
                t        = t - {1'b0, div};
                q_nxt[0] = 1'b1;
            end
            r_nxt = t[W-1:0];
        end
    end

    always_comb begin
        res_q = q_neg ? -q_nxt : q_nxt;
        res_r = r_neg ? -r_nxt : r_nxt;
        if (zero) begin
            res_q = '1;
            res_r = dvd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            s_ready       <= 1'b1;
            m_valid       <= 1'b0;
            m_quotient    <= '0;
            m_remainder   <= '0;
            m_div_by_zero <= 1'b0;
            m_user        <= '0;
            cnt           <= '0;
            rem           <= '0;
            quo           <= '0;
            div           <= '0;
            dvd           <= '0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            zero          <= 1'b0;
            user          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        quo     <= a_neg ? -s_dividend : s_dividend;
                        div     <= b_neg ? -s_divisor : s_divisor;
                        dvd     <= s_dividend;
                        rem     <= '0;
                        q_neg   <= a_neg ^ b_neg;
                        r_neg   <= a_neg;
                        zero    <= (s_divisor == '0);
                        user    <= s_user;
                        cnt     <= '0;
                        s_ready <= 1'b0;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    rem <= r_nxt;
                    quo <= q_nxt;
                    cnt <= cnt + CW'(1);
                    if (finish) begin
                        m_quotient    <= res_q;
                        m_remainder   <= res_r;
                        m_div_by_zero <= zero;
                        m_user        <= user;
                        m_valid       <= 1'b1;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jelly_cpu_divider_stream.sv
// Bench for jelly_cpu_divider_stream: three instances (1, 2 and 4 bits per cycle) share the
// request stream; a negedge monitor compares every result against an arithmetic model.
module tb_jelly_cpu_divider_stream;

    localparam int W  = 32;
    localparam int UW = 4;

`ifdef JELLY_CPU_DIVIDER_ZERO_FAST_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_signed;
    logic [W-1:0]  s_dividend;
    logic [W-1:0]  s_divisor;
    logic [UW-1:0] s_user;
    logic          m_ready [3];

    logic          s_ready [3];
    logic          m_valid [3];
    logic [W-1:0]  m_q     [3];
    logic [W-1:0]  m_r     [3];
    logic          m_z     [3];
    logic [UW-1:0] m_u     [3];

    int            n_chk  = 0;
    int            n_fail = 0;
    int            cycle  = 0;
    bit            rnd_mr = 1'b0;

    logic [W-1:0]  exp_q;
    logic [W-1:0]  exp_r;
    logic          exp_z;
    logic [UW-1:0] exp_u;

    bit            pend [3];
    bit            prev_v [3];
    int            acc [3];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : gen_dut
            localparam int BPC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
            jelly_cpu_divider_stream #(
                .DATA_WIDTH    (W),
                .BITS_PER_CYCLE(BPC),
                .USER_WIDTH    (UW)
            ) u_dut (
                .clk          (clk),
                .reset        (reset),
                .s_valid      (s_valid),
                .s_ready      (s_ready[g]),
                .s_signed     (s_signed),
                .s_dividend   (s_dividend),
                .s_divisor    (s_divisor),
                .s_user       (s_user),
                .m_valid      (m_valid[g]),
                .m_ready      (m_ready[g]),
                .m_quotient   (m_q[g]),
                .m_remainder  (m_r[g]),
                .m_div_by_zero(m_z[g]),
                .m_user       (m_u[g])
            );
        end
    endgenerate

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        longint sa;
        longint sb;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    function automatic int exp_lat(input int k);
        int n;
        n = 32 / ((k == 0) ? 1 : (k == 1) ? 2 : 4);
        return (exp_z && ZF) ? 2 : n + 1;
    endfunction

    // compare process: latency on the rising m_valid, values on every valid cycle
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                pend[k]   = 1'b0;
                prev_v[k] = 1'b0;
            end else begin
                if (pend[k]) begin
                    if (m_valid[k]) begin
                        if (!prev_v[k])
                            chk($sformatf("latency[%0d]", k), 64'(cycle - acc[k]), 64'(exp_lat(k)));
                        chk($sformatf("quotient[%0d]", k), m_q[k], exp_q);
                        chk($sformatf("remainder[%0d]", k), m_r[k], exp_r);
                        chk($sformatf("div_by_zero[%0d]", k), m_z[k], exp_z);
                        chk($sformatf("user[%0d]", k), m_u[k], exp_u);
                        if (m_ready[k]) pend[k] = 1'b0;
                    end
                end else begin
                    chk($sformatf("spurious_valid[%0d]", k), m_valid[k], 1'b0);
                end
                if (s_valid && s_ready[k]) begin
                    pend[k] = 1'b1;
                    acc[k]  = cycle;
                end
                prev_v[k] = m_valid[k];
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_mr)
                for (int k = 0; k < 3; k++) m_ready[k] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(s_ready[0] && s_ready[1] && s_ready[2]) && k < 300) begin
            tick();
            k++;
        end
        chk("idle_timeout", {s_ready[0], s_ready[1], s_ready[2]}, 3'b111);
    endtask

    task automatic issue(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [UW-1:0] u);
        wait_idle();
        model(sg, a, b, exp_q, exp_r, exp_z);
        exp_u      = u;
        s_signed   = sg;
        s_dividend = a;
        s_divisor  = b;
        s_user     = u;
        s_valid    = 1'b1;
        tick();
        s_valid    = 1'b0;
    endtask

    task automatic issue_dir(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [UW-1:0] u, input logic [W-1:0] eq,
                             input logic [W-1:0] er, input logic ez);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        model(sg, a, b, q, r, z);
        chk("model_q", q, eq);
        chk("model_r", r, er);
        chk("model_z", z, ez);
        issue(sg, a, b, u);
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_s_ready[%0d]", k), s_ready[k], 1'b1);
            chk($sformatf("rst_m_valid[%0d]", k), m_valid[k], 1'b0);
            chk($sformatf("rst_q[%0d]", k), m_q[k], '0);
            chk($sformatf("rst_r[%0d]", k), m_r[k], '0);
            chk($sformatf("rst_z[%0d]", k), m_z[k], 1'b0);
            chk($sformatf("rst_u[%0d]", k), m_u[k], '0);
        end
    endtask

    function automatic logic [W-1:0] rand_val(input bit div);
        case ($urandom_range(0, 6))
            0:       return div ? W'($urandom_range(0, 3)) : '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return W'($urandom_range(0, 20));
            4:       return -W'($urandom_range(1, 20));
            5:       return W'($urandom) >> $urandom_range(0, 31);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        reset      = 1'b1;
        s_valid    = 1'b0;
        s_signed   = 1'b0;
        s_dividend = '0;
        s_divisor  = '0;
        s_user     = '0;
        for (int k = 0; k < 3; k++) m_ready[k] = 1'b1;
        tick(3);
        reset = 1'b0;
        check_reset_state();

        issue_dir(1'b0, 32'd100, 32'd7, 4'h1, 32'd14, 32'd2, 1'b0);
        issue_dir(1'b1, 32'd7, -32'd3, 4'h2, -32'd2, 32'd1, 1'b0);
        issue_dir(1'b1, -32'd7, 32'd3, 4'h3, -32'd2, -32'd1, 1'b0);
        issue_dir(1'b1, -32'd7, -32'd3, 4'h4, 32'd2, -32'd1, 1'b0);
        issue_dir(1'b0, 32'd7, 32'hFFFF_FFFD, 4'h5, 32'd0, 32'd7, 1'b0);
        issue_dir(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h6, 32'h8000_0000, 32'd0, 1'b0);
        issue_dir(1'b0, 32'hFFFF_FFFF, 32'd1, 4'h7, 32'hFFFF_FFFF, 32'd0, 1'b0);
        issue_dir(1'b1, 32'hFFFF_FFF9, 32'd0, 4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
        issue_dir(1'b0, 32'd123, 32'd0, 4'h9, 32'hFFFF_FFFF, 32'd123, 1'b1);

        // consumer stalls for 10 cycles in DONE
        wait_idle();
        for (int k = 0; k < 3; k++) m_ready[k] = 1'b0;
        issue_dir(1'b0, 32'd1000, 32'd33, 4'hA, 32'd30, 32'd10, 1'b0);
        begin
            int n = 0;
            while (!(m_valid[0] && m_valid[1] && m_valid[2]) && n < 60) begin
                tick();
                n++;
            end
        end
        tick(10);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold_s_ready[%0d]", k), s_ready[k], 1'b0);
            chk($sformatf("hold_m_valid[%0d]", k), m_valid[k], 1'b1);
            m_ready[k] = 1'b1;
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("release_s_ready[%0d]", k), s_ready[k], 1'b1);
            chk($sformatf("release_m_valid[%0d]", k), m_valid[k], 1'b0);
        end

        // reset in the middle of CALC discards the operation
        issue(1'b0, 32'd100, 32'd7, 4'hB);
        tick(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state();
        tick(40);
        issue_dir(1'b0, 32'd9, 32'd2, 4'hC, 32'd4, 32'd1, 1'b0);

        // random operands with random request gaps and consumer stalls
        rnd_mr = 1'b1;
        for (int i = 0; i < 800; i++) begin
            tick($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), rand_val(1'b0), rand_val(1'b1), UW'($urandom));
        end
        wait_idle();
        rnd_mr = 1'b0;
        for (int k = 0; k < 3; k++) m_ready[k] = 1'b1;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
